// File: rtl/sub8b_seq.sv
// Sequential 8-bit subtractor: computes inA - inB - bin two bits per cycle
// over four cycles, with a start/busy/done handshake and held result flags.
module sub8b_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] inA,
  input  logic [7:0] inB,
  input  logic       bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] diff,
  output logic       bout,
  output logic       zero,
  output logic       ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t     state;
  logic [1:0] step;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic       carry;
  logic [7:0] partial;

  logic [2:0] idx;
  logic [2:0] slice_sum;
  logic [7:0] p_next;

  // Subtraction as A + ~B + carry, where carry starts as ~bin.
  always_comb begin
    idx       = {step, 1'b0};
    slice_sum = {1'b0, a_reg[idx +: 2]} + {1'b0, ~b_reg[idx +: 2]} + {2'b00, carry};
    p_next    = partial;
    p_next[idx +: 2] = slice_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      step    <= 2'd0;
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      carry   <= 1'b0;
      partial <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= 8'h00;
      bout    <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_reg   <= inA;
            b_reg   <= inB;
            carry   <= ~bin;
            step    <= 2'd0;
            partial <= 8'h00;
            busy    <= 1'b1;
            state   <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          partial <= p_next;
          carry   <= slice_sum[2];
          if (step == 2'd3) begin
            // Final slice: results are taken from the freshly completed partial.
            diff  <= p_next;
            bout  <= ~slice_sum[2];
            zero  <= (p_next == 8'h00);
            ovf   <= (a_reg[7] ^ b_reg[7]) & (p_next[7] ^ a_reg[7]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub8b_seq.sv
// Directed self-checking bench for sub8b_seq: reset, arithmetic corner cases,
// handshake timing, back-to-back starts and reset during an operation.
module tb_sub8b_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       zero;
  logic       ovf;

  int compared;
  int mismatched;
  logic [7:0] prev_diff;
  int done_count;

  sub8b_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .inA   (inA),
    .inB   (inB),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".diff"}, {24'd0, diff}, 32'd0);
    checkOutput({tag, ".bout"}, {31'd0, bout}, 32'd0);
    checkOutput({tag, ".zero"}, {31'd0, zero}, 32'd0);
    checkOutput({tag, ".ovf"},  {31'd0, ovf},  32'd0);
  endtask

  // Drive a start pulse during cycle 0 (called at a negedge); returns in cycle 1.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bi);
    inA   = a;
    inB   = b;
    bin   = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full operation with expected flags; returns in the cycle after done.
  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bi, input logic [7:0] exp_diff, input logic exp_bout,
                       input logic exp_zero, input logic exp_ovf);
    applyStimulus(a, b, bi);
    inA = ~a;
    inB = ~b;
    bin = ~bi;
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("%s.busy_c%0d", tag, c), {31'd0, busy}, 32'd1);
      checkOutput($sformatf("%s.done_c%0d", tag, c), {31'd0, done}, 32'd0);
      checkOutput($sformatf("%s.hold_c%0d", tag, c), {24'd0, diff}, {24'd0, prev_diff});
      @(negedge clk);
    end
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".diff"}, {24'd0, diff}, {24'd0, exp_diff});
    checkOutput({tag, ".bout"}, {31'd0, bout}, {31'd0, exp_bout});
    checkOutput({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
    checkOutput({tag, ".ovf"},  {31'd0, ovf},  {31'd0, exp_ovf});
    prev_diff = exp_diff;
    @(negedge clk);
    checkOutput({tag, ".done_off"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".diff_held"}, {24'd0, diff}, {24'd0, exp_diff});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    prev_diff  = 8'h00;
    rst_n      = 1'b0;
    start      = 1'b1;
    inA        = 8'($urandom);
    inB        = 8'($urandom);
    bin        = 1'($urandom);

    // Reset held with start asserted.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkAllZero($sformatf("rst_c%0d", c));
    end
    rst_n = 1'b1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkAllZero($sformatf("idle_c%0d", c));
    end

    runOp("basic",  8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    runOp("wrap",   8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);
    runOp("wrapz",  8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    runOp("ovf",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    runOp("zero",   8'h05, 8'h04, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

    // Handshake: a start during CALC is ignored, start in DONE is accepted.
    done_count = 0;
    applyStimulus(8'h50, 8'h20, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin
        inA   = 8'hFF;
        inB   = 8'h00;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) done_count++;
      checkOutput($sformatf("hs.busy_c%0d", c), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    start = 1'b0;
    if (done) done_count++;
    checkOutput("hs.done_c5", {31'd0, done}, 32'd1);
    checkOutput("hs.diff_c5", {24'd0, diff}, 32'h30);
    inA   = 8'h09;
    inB   = 8'h03;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      if (done) done_count++;
      checkOutput($sformatf("hs.busy_c%0d", c), {31'd0, busy}, 32'd1);
      checkOutput($sformatf("hs.hold_c%0d", c), {24'd0, diff}, 32'h30);
      @(negedge clk);
    end
    checkOutput("hs.done_count", done_count, 32'd1);
    checkOutput("hs.done_c10", {31'd0, done}, 32'd1);
    checkOutput("hs.diff_c10", {24'd0, diff}, 32'h06);
    checkOutput("hs.busy_c10", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("hs.done_c11", {31'd0, done}, 32'd0);

    // Reset in cycle 3 of an operation: outputs clear, no done appears.
    applyStimulus(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev_diff = 8'h00;
    for (int c = 4; c <= 7; c++) begin
      checkAllZero($sformatf("midrst_c%0d", c));
      @(negedge clk);
    end
    runOp("after_rst", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no end, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
